// File: rtl/uart_tx_fifo.sv
// UART transmitter with a built-in transmit FIFO and a configurable frame format.
// Producers push characters with a one-cycle strobe; frames go out back-to-back while data is queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BOUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [DATA_BITS-1:0]                 wr_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 overflow,
    output logic                                 tx_pin,
    output logic                                 busy
);

    localparam int CYCLE = CLK_FREQ / BOUD_RATE;
    localparam int TW    = (CYCLE > 2) ? $clog2(CYCLE) : 1;
    localparam int BW    = $clog2(DATA_BITS);
    localparam int PW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    if (PARITY < 0 || PARITY > 2) begin : gBadParity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
        $error("uart_tx_fifo: DATA_BITS must be within 5..9");
    end
    if (CYCLE < 2) begin : gBadCycle
        $error("uart_tx_fifo: CLK_FREQ/BOUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr_q, wrPtr_d;
    logic [PW-1:0]        rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic [BW-1:0]        bitIdx_q;
    logic                 stopIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 busy_q;

    logic                 fifoFull, fifoEmpty;
    logic                 push, pop;
    logic                 bitEnd, frameEnd;
    logic [DATA_BITS-1:0] headData;
    logic                 headParity;

    assign fifoFull   = (count_q == CW'(FIFO_DEPTH));
    assign fifoEmpty  = (count_q == '0);
    assign bitEnd     = (timer_q == TW'(CYCLE - 1));
    assign frameEnd   = (state_q == ST_STOP) && bitEnd && (stopIdx_q == 1'(STOP_BITS - 1));
    // The FSM consumes the head either from idle or straight at the end of the last stop bit.
    assign pop        = !fifoEmpty && ((state_q == ST_IDLE) || frameEnd);
    assign push       = wr_en && !fifoFull;
    assign headData   = mem_q[rdPtr_q];
    assign headParity = (PARITY == 1) ? ~^headData : ^headData;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= wr_en && fifoFull;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= headData;
                        parity_q <= headParity;
                        timer_q  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (bitEnd) begin
                        timer_q <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bitEnd) begin
                        timer_q <= '0;
                        if (bitIdx_q == BW'(DATA_BITS - 1)) begin
                            bitIdx_q  <= '0;
                            stopIdx_q <= 1'b0;
                            if (PARITY != 0) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bitIdx_q <= bitIdx_q + BW'(1);
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bitEnd) begin
                        timer_q   <= '0;
                        stopIdx_q <= 1'b0;
                        tx_q      <= 1'b1;
                        state_q   <= ST_STOP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (bitEnd) begin
                        timer_q <= '0;
                        if (!frameEnd) begin
                            stopIdx_q <= 1'b1;
                        end else if (pop) begin
                            stopIdx_q <= 1'b0;
                            shift_q   <= headData;
                            parity_q  <= headParity;
                            tx_q      <= 1'b0;
                            state_q   <= ST_START;
                        end else begin
                            stopIdx_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign full     = fifoFull;
    assign empty    = fifoEmpty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_pin   = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame vectors on four frame formats plus
// a randomized FIFO/overflow run on a fast, shallow instance checked against a queue model.
module tb_uart_tx_fifo;

    localparam int CYC   = 27_000_000 / 115200;
    localparam int CYC4  = 4;
    localparam int DEP4  = 4;
    localparam int LEN4  = 10 * CYC4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn   [5];
    logic [7:0] wrData [5];
    logic       tx     [5];
    logic       busy   [5];
    logic       full   [5];
    logic       empty  [5];
    logic       ovf    [5];
    logic [4:0] cnt    [4];
    logic [2:0] cnt4;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    uart_tx_fifo dut0 (
        .clk(clk), .rst(rst), .wr_en(wrEn[0]), .wr_data(wrData[0]), .full(full[0]),
        .empty(empty[0]), .count(cnt[0]), .overflow(ovf[0]), .tx_pin(tx[0]), .busy(busy[0]));
    uart_tx_fifo #(.PARITY(2)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn[1]), .wr_data(wrData[1]), .full(full[1]),
        .empty(empty[1]), .count(cnt[1]), .overflow(ovf[1]), .tx_pin(tx[1]), .busy(busy[1]));
    uart_tx_fifo #(.PARITY(1)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wrEn[2]), .wr_data(wrData[2]), .full(full[2]),
        .empty(empty[2]), .count(cnt[2]), .overflow(ovf[2]), .tx_pin(tx[2]), .busy(busy[2]));
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wrEn[3]), .wr_data(wrData[3][6:0]), .full(full[3]),
        .empty(empty[3]), .count(cnt[3]), .overflow(ovf[3]), .tx_pin(tx[3]), .busy(busy[3]));
    uart_tx_fifo #(.CLK_FREQ(4), .BOUD_RATE(1), .FIFO_DEPTH(DEP4)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wrEn[4]), .wr_data(wrData[4]), .full(full[4]),
        .empty(empty[4]), .count(cnt4), .overflow(ovf[4]), .tx_pin(tx[4]), .busy(busy[4]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] getCount(input int idx);
        if (idx == 4) return 32'(cnt4);
        return 32'(cnt[idx]);
    endfunction

    // Line level of bit k of a frame: start, data LSB first, optional parity, then stop bits.
    function automatic logic expBit(input logic [7:0] data, input int dbits, input int par, input int k);
        int ones;
        ones = 0;
        for (int i = 0; i < dbits; i++) ones += int'(data[i]);
        if (k == 0) return 1'b0;
        if (k <= dbits) return data[k-1];
        if (par != 0 && k == dbits + 1) return (par == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic applyStimulus(input int idx, input logic [7:0] data);
        wrEn[idx]   = 1'b1;
        wrData[idx] = data;
        @(negedge clk);
        wrEn[idx]   = 1'b0;
    endtask

    // Called on the sample at frame offset t0 (0 = first start-bit cycle).
    task automatic checkFrame(input int idx, input logic [7:0] data, input int dbits, input int par,
                              input int expLen, input int t0, input bit lastFrame, input string tag);
        for (int t = t0; t < expLen; t++) begin
            if (t % CYC == 0 || t % CYC == CYC / 2 || t % CYC == CYC - 1)
                checkOutput($sformatf("%s tx t=%0d", tag, t), tx[idx], expBit(data, dbits, par, t / CYC));
            if (t % CYC == 0 || t == expLen - 1)
                checkOutput($sformatf("%s busy t=%0d", tag, t), busy[idx], 1);
            @(negedge clk);
        end
        if (lastFrame) begin
            checkOutput({tag, " busy after frame"}, busy[idx], 0);
            checkOutput({tag, " tx after frame"}, tx[idx], 1);
            checkOutput({tag, " empty after frame"}, empty[idx], 1);
        end
    endtask

    // Reference model for dut4: queue occupancy plus remaining cycles of the frame on the line.
    int         mSize = 0;
    int         mRem  = 0;
    logic       mOvf  = 1'b0;
    logic [7:0] expQ [$];
    bit         checkModel = 1'b0;

    initial begin
        bit popNow;
        forever begin
            @(posedge clk);
            if (rst) begin
                mSize = 0;
                mRem  = 0;
                mOvf  = 1'b0;
                expQ.delete();
            end else begin
                popNow = 1'b0;
                if (mRem > 0) mRem--;
                if (mRem == 0 && mSize > 0) begin
                    popNow = 1'b1;
                    mRem   = LEN4;
                end
                mOvf = wrEn[4] && (mSize == DEP4);
                if (wrEn[4] && mSize < DEP4) begin
                    expQ.push_back(wrData[4]);
                    mSize++;
                end
                if (popNow) mSize--;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkModel && !rst) begin
                checkOutput("dut4 count", getCount(4), mSize);
                checkOutput("dut4 full", full[4], (mSize == DEP4) ? 1 : 0);
                checkOutput("dut4 empty", empty[4], (mSize == 0) ? 1 : 0);
                checkOutput("dut4 overflow", ovf[4], mOvf);
            end
        end
    end

    // Line decoder for dut4, sampling mid-bit; decoded bytes are scored against accepted writes.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx[4] === 1'b0) begin
                repeat (CYC4 / 2) @(negedge clk);
                checkOutput("dut4 start bit", tx[4], 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CYC4) @(negedge clk);
                    b[k] = tx[4];
                end
                repeat (CYC4) @(negedge clk);
                checkOutput("dut4 stop bit", tx[4], 1);
                if (expQ.size() == 0) checkOutput("dut4 unexpected frame", 1, 0);
                else checkOutput("dut4 rx byte", b, expQ.pop_front());
                repeat (CYC4 - CYC4 / 2 - 1) @(negedge clk);
            end
        end
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         dbits;
        int         par;
        int         expLen;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int ovfSeen;
        vecs[0] = '{0, 8'h41, 8, 0, 2340};
        vecs[1] = '{1, 8'h41, 8, 2, 2574};
        vecs[2] = '{2, 8'h41, 8, 1, 2574};
        vecs[3] = '{3, 8'h41, 7, 0, 2340};
        vecs[4] = '{1, 8'hB7, 8, 2, 2574};
        vecs[5] = '{2, 8'h00, 8, 1, 2574};

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrEn[i]   = 1'b0;
            wrData[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("reset tx%0d", i), tx[i], 1);
            checkOutput($sformatf("reset busy%0d", i), busy[i], 0);
            checkOutput($sformatf("reset empty%0d", i), empty[i], 1);
            checkOutput($sformatf("reset full%0d", i), full[i], 0);
            checkOutput($sformatf("reset count%0d", i), getCount(i), 0);
            checkOutput($sformatf("reset overflow%0d", i), ovf[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            applyStimulus(vecs[v].inst, vecs[v].data);
            checkOutput({tag, " empty after write"}, empty[vecs[v].inst], 0);
            checkOutput({tag, " count after write"}, getCount(vecs[v].inst), 1);
            checkOutput({tag, " busy after write"}, busy[vecs[v].inst], 0);
            @(negedge clk);
            checkOutput({tag, " count after pop"}, getCount(vecs[v].inst), 0);
            checkFrame(vecs[v].inst, vecs[v].data, vecs[v].dbits, vecs[v].par, vecs[v].expLen, 0, 1'b1, tag);
        end

        // Burst of three on consecutive cycles; frames must follow without idle gaps.
        wrEn[0] = 1'b1; wrData[0] = 8'h41;
        @(negedge clk);
        checkOutput("burst count e0", getCount(0), 1);
        wrData[0] = 8'h42;
        @(negedge clk);
        checkOutput("burst count e1", getCount(0), 1);
        checkOutput("burst onset tx", tx[0], 0);
        wrData[0] = 8'h43;
        @(negedge clk);
        wrEn[0] = 1'b0;
        checkOutput("burst count peak", getCount(0), 2);
        checkFrame(0, 8'h41, 8, 0, 2340, 1, 1'b0, "burst0");
        checkFrame(0, 8'h42, 8, 0, 2340, 0, 1'b0, "burst1");
        checkFrame(0, 8'h43, 8, 0, 2340, 0, 1'b1, "burst2");

        // Asynchronous reset in the middle of data bit 3.
        applyStimulus(0, 8'h41);
        @(negedge clk);
        repeat (4 * CYC + CYC / 2) @(negedge clk);
        checkOutput("midframe bit3 low", tx[0], expBit(8'h41, 8, 0, 4));
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset tx", tx[0], 1);
        checkOutput("async reset busy", busy[0], 0);
        checkOutput("async reset empty", empty[0], 1);
        checkOutput("async reset count", getCount(0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, 8'h55);
        checkOutput("post-reset count", getCount(0), 1);
        @(negedge clk);
        checkFrame(0, 8'h55, 8, 0, 2340, 0, 1'b1, "post-reset");

        // Overflow on the shallow instance while its line is busy.
        checkModel = 1'b1;
        applyStimulus(4, 8'h10);
        @(negedge clk);
        checkOutput("dut4 busy before burst", busy[4], 1);
        ovfSeen = 0;
        for (int i = 0; i < 6; i++) begin
            wrEn[4]   = 1'b1;
            wrData[4] = 8'(8'h20 + i);
            @(negedge clk);
            if (ovf[4] === 1'b1) ovfSeen++;
        end
        wrEn[4] = 1'b0;
        checkOutput("dut4 full after burst", full[4], 1);
        @(negedge clk);
        if (ovf[4] === 1'b1) ovfSeen++;
        checkOutput("dut4 overflow pulses", ovfSeen, 6 - DEP4);
        n = 0;
        while ((expQ.size() != 0 || busy[4] !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("dut4 overflow drain pending", expQ.size(), 0);
        checkOutput("dut4 overflow drain busy", busy[4], 0);

        // Randomized writes against the queue model.
        for (int c = 0; c < 400; c++) begin
            wrEn[4]   = ($urandom_range(0, 5) == 0);
            wrData[4] = 8'($urandom);
            @(negedge clk);
        end
        wrEn[4] = 1'b0;
        n = 0;
        while ((expQ.size() != 0 || busy[4] !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("dut4 random drain pending", expQ.size(), 0);
        checkOutput("dut4 random drain busy", busy[4], 0);
        checkOutput("dut4 random tx idle", tx[4], 1);
        checkModel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
